// File: rtl/kbd_scancode_fifo.sv
// Receive FIFO for PS/2 scancode bytes, exposed on the CPU IOBUS as head/status/control words.
// Also raises a one-cycle interrupt pulse for every byte that is actually buffered.
module kbd_scancode_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] DATA_AD = 32'h1100_0100,
  parameter logic [31:0] STAT_AD = 32'h1100_0104,
  parameter logic [31:0] CTRL_AD = 32'h1100_0108
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SC_VALID,
  input  logic [7:0]  SC_DATA,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          ie;

  logic ctrl_wr;
  logic flush;
  logic ovf_clr;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic ctrl_unused;

  assign ctrl_wr     = IOBUS_WR && (IOBUS_ADDR == CTRL_AD);
  assign flush       = ctrl_wr && IOBUS_OUT[1];
  assign ovf_clr     = ctrl_wr && IOBUS_OUT[2];
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign ctrl_unused = ^IOBUS_OUT[31:4];

  // Flush suppresses both sides; a pop frees a slot so a full FIFO still accepts the byte.
  assign pop  = ctrl_wr && IOBUS_OUT[0] && !empty && !flush;
  assign push = SC_VALID && !flush && (!full || pop);
  assign drop = SC_VALID && !flush && full && !pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ie     <= 1'b0;
      INTR   <= 1'b0;
    end else begin
      INTR <= push && ie;
      ovf  <= (ovf && !ovf_clr) || drop;
      if (ctrl_wr) begin
        ie <= IOBUS_OUT[3];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= SC_DATA;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == DATA_AD) begin
      if (!empty) begin
        IOBUS_IN = {24'b0, mem[rd_ptr]};
      end
    end else if (IOBUS_ADDR == STAT_AD) begin
      IOBUS_IN = {19'b0, 5'(count), 5'b0, ovf, full, !empty};
    end else if (IOBUS_ADDR == CTRL_AD) begin
      IOBUS_IN = {28'b0, ie, 3'b0};
    end
  end

endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// Scoreboard bench for kbd_scancode_fifo: a queue-based byte model predicts every read and INTR,
// and a negedge monitor consumes one expectation per clock cycle.
module tb_kbd_scancode_fifo;

  localparam int unsigned DEPTH    = 16;
  localparam logic [31:0] DATA_AD  = 32'h1100_0100;
  localparam logic [31:0] STAT_AD  = 32'h1100_0104;
  localparam logic [31:0] CTRL_AD  = 32'h1100_0108;
  localparam logic [31:0] OTHER_AD = 32'h1100_0110;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SC_VALID = 1'b0;
  logic [7:0]  SC_DATA = '0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  kbd_scancode_fifo #(
    .DEPTH  (DEPTH),
    .DATA_AD(DATA_AD),
    .STAT_AD(STAT_AD),
    .CTRL_AD(CTRL_AD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SC_VALID  (SC_VALID),
    .SC_DATA   (SC_DATA),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .INTR      (INTR)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  byte unsigned mq[$];
  logic m_ovf  = 1'b0;
  logic m_ie   = 1'b0;
  logic m_intr = 1'b0;

  // Scoreboard queues: one entry per cycle
  string       name_q[$];
  logic [31:0] rd_q[$];
  logic        intr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  string       mon_name;
  logic [31:0] mon_rd;
  logic        mon_intr;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] r;
    int unsigned n;
    r = '0;
    n = mq.size();
    if (a == DATA_AD) begin
      if (n > 0) r = {24'b0, mq[0]};
    end else if (a == STAT_AD) begin
      r[12:8] = 5'(n);
      r[2]    = m_ovf;
      r[1]    = (n == DEPTH);
      r[0]    = (n != 0);
    end else if (a == CTRL_AD) begin
      r[3] = m_ie;
    end
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic sv, input logic [7:0] d,
                            input logic [31:0] a, input logic [31:0] wd, input logic wr);
    logic ctl, fl, full0, popped, pushed, dropped;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_ie   = 1'b0;
      m_intr = 1'b0;
      return;
    end
    ctl     = wr && (a == CTRL_AD);
    fl      = ctl && wd[1];
    full0   = (mq.size() == DEPTH);
    popped  = 1'b0;
    pushed  = 1'b0;
    dropped = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (ctl && wd[0] && mq.size() > 0) begin
        void'(mq.pop_front());
        popped = 1'b1;
      end
      if (sv) begin
        if (!full0 || popped) begin
          mq.push_back(d);
          pushed = 1'b1;
        end else begin
          dropped = 1'b1;
        end
      end
    end
    m_intr = pushed && m_ie;
    m_ovf  = (m_ovf && !(ctl && wd[2])) || dropped;
    if (ctl) m_ie = wd[3];
  endtask

  // Drive one cycle; the expected read/INTR come from the pre-edge model state.
  task automatic cyc(input logic rst, input logic sv, input logic [7:0] d, input logic [31:0] a,
                     input logic [31:0] wd, input logic wr, input string nm,
                     input logic usec = 1'b0, input logic [31:0] cval = '0);
    RST        = rst;
    SC_VALID   = sv;
    SC_DATA    = d;
    IOBUS_ADDR = a;
    IOBUS_OUT  = wd;
    IOBUS_WR   = wr;
    name_q.push_back(nm);
    rd_q.push_back(usec ? cval : exp_read(a));
    intr_q.push_back(m_intr);
    @(posedge CLK);
    model_step(rst, sv, d, a, wd, wr);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, OTHER_AD, '0, 1'b0, "push");
  endtask

  task automatic rdc(input logic [31:0] a, input string nm, input logic [31:0] v);
    cyc(1'b0, 1'b0, 8'h00, a, '0, 1'b0, nm, 1'b1, v);
  endtask

  task automatic rdm(input logic [31:0] a, input string nm);
    cyc(1'b0, 1'b0, 8'h00, a, '0, 1'b0, nm);
  endtask

  task automatic ctl(input logic [31:0] wd, input logic sv, input logic [7:0] d, input string nm);
    cyc(1'b0, sv, d, CTRL_AD, wd, 1'b1, nm);
  endtask

  always @(negedge CLK) begin
    if (rd_q.size() > 0) begin
      mon_name = name_q.pop_front();
      mon_rd   = rd_q.pop_front();
      mon_intr = intr_q.pop_front();
      n_checks = n_checks + 1;
      if (IOBUS_IN !== mon_rd) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: IOBUS_IN=%h expected %h (t=%0t)", mon_name, IOBUS_IN, mon_rd, $time);
      end
      n_checks = n_checks + 1;
      if (INTR !== mon_intr) begin
        n_fail = n_fail + 1;
        $display("FAIL intr@%s: INTR=%b expected %b (t=%0t)", mon_name, INTR, mon_intr, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  x;
    logic [31:0] wd;
    logic [31:0] a;
    logic        sv, wr, rs;
    int unsigned mode;

    @(posedge CLK);
    #1;

    // Reset state
    cyc(1'b1, 1'b0, 8'h00, DATA_AD, '0, 1'b0, "reset");
    rdc(DATA_AD, "rst_data", 32'h0);
    rdc(STAT_AD, "rst_stat", 32'h0);
    rdc(CTRL_AD, "rst_ctrl", 32'h0);

    // Single byte with interrupt enabled
    ctl(32'h8, 1'b0, 8'h00, "set_ie");
    rdc(CTRL_AD, "ie_read", 32'h8);
    cyc(1'b0, 1'b1, 8'h1C, DATA_AD, '0, 1'b0, "push_1c");
    rdc(DATA_AD, "head_1c", 32'h1C);
    rdc(STAT_AD, "stat_one", 32'h101);
    ctl(32'h9, 1'b0, 8'h00, "pop_1c");
    rdc(STAT_AD, "stat_empty", 32'h0);

    // Break-code burst
    push(8'hE0);
    push(8'hF0);
    push(8'h6B);
    rdc(DATA_AD, "burst_e0", 32'hE0);
    ctl(32'h9, 1'b0, 8'h00, "pop");
    rdc(DATA_AD, "burst_f0", 32'hF0);
    ctl(32'h9, 1'b0, 8'h00, "pop");
    rdc(DATA_AD, "burst_6b", 32'h6B);
    ctl(32'h9, 1'b0, 8'h00, "pop");
    rdc(DATA_AD, "burst_empty", 32'h0);

    // Overflow: 17 bytes into 16 slots
    for (int i = 0; i < 17; i++) push(8'(i));
    rdc(STAT_AD, "stat_ovf_full", 32'h1007);
    for (int i = 0; i < 16; i++) begin
      rdc(DATA_AD, "drain_ovf", 32'(i));
      ctl(32'h9, 1'b0, 8'h00, "pop");
    end
    rdc(DATA_AD, "ovf_dropped", 32'h0);
    rdc(STAT_AD, "stat_ovf_empty", 32'h4);
    ctl(32'hC, 1'b0, 8'h00, "ovf_clr");
    rdc(STAT_AD, "stat_ovf_clr", 32'h0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    ctl(32'h9, 1'b1, 8'hAA, "push_pop_full");
    rdc(STAT_AD, "stat_pp_full", 32'h1003);
    for (int i = 1; i < 16; i++) begin
      rdc(DATA_AD, "drain_pp", 32'(8'h20 + i));
      ctl(32'h9, 1'b0, 8'h00, "pop");
    end
    rdc(DATA_AD, "last_aa", 32'hAA);
    ctl(32'h9, 1'b0, 8'h00, "pop");
    rdc(STAT_AD, "stat_pp_empty", 32'h0);

    // Pointer wrap with three resident bytes
    for (int i = 0; i < 3; i++) push(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      ctl(32'h9, 1'b1, x, "wrap_pp");
      rdm(DATA_AD, "wrap_head");
    end
    for (int i = 0; i < 3; i++) begin
      rdm(DATA_AD, "wrap_drain");
      ctl(32'h9, 1'b0, 8'h00, "pop");
    end
    rdc(DATA_AD, "wrap_empty", 32'h0);

    // Flush beats a same-cycle push
    push(8'h31);
    push(8'h32);
    ctl(32'hA, 1'b1, 8'h55, "flush_push");
    rdc(STAT_AD, "stat_flush", 32'h0);
    rdc(DATA_AD, "data_flush", 32'h0);

    // Reset beats a same-cycle push and control write
    push(8'h77);
    cyc(1'b1, 1'b1, 8'h88, CTRL_AD, 32'h9, 1'b1, "rst_push");
    rdc(DATA_AD, "rst2_data", 32'h0);
    rdc(STAT_AD, "rst2_stat", 32'h0);
    rdc(CTRL_AD, "rst2_ctrl", 32'h0);

    // Randomized traffic alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 600; i++) begin
      mode = (i / 100) % 2;
      rs = ($urandom_range(0, 199) == 0);
      sv = ($urandom_range(0, 99) < (mode != 0 ? 20 : 70));
      x  = 8'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 7) != 0) wd[1] = 1'b0;
      if ($urandom_range(0, 99) < (mode != 0 ? 70 : 25)) begin
        a  = CTRL_AD;
        wr = 1'b1;
        wd[0] = 1'b1;
        if ($urandom_range(0, 3) != 0) wd[3] = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          0: a = DATA_AD;
          1: a = STAT_AD;
          2: a = CTRL_AD;
          default: a = OTHER_AD;
        endcase
        wr = ($urandom_range(0, 3) == 0);
      end
      cyc(rs, sv, x, a, wd, wr, "random");
    end

    RST      = 1'b0;
    SC_VALID = 1'b0;
    IOBUS_WR = 1'b0;
    @(negedge CLK);
    #1;
    n_checks = n_checks + 1;
    if (rd_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_scancode_fifo.md
# kbd_scancode_fifo

Memory-mapped receive FIFO between the PS/2 keyboard driver and the CPU IOBUS. Scancode bytes arriving as single-cycle strobes are buffered so bursts (make/break sequences such as F0 xx, E0 F0 xx) are not lost while the CPU is busy. The FIFO head, a status word and a control word are exposed on the IOBUS. A one-cycle interrupt pulse is raised per received byte. The wrapper's read mux and `INTR` source connect to this block instead of reading the driver's scancode directly.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DATA_AD`, 32'h11000100: head-of-FIFO read address.
- `STAT_AD`, 32'h11000104: status read address.
- `CTRL_AD`, 32'h11000108: control read/write address.

Ports:
- `CLK`  in  1: system clock (the 50 MHz CPU clock); single clock domain.
- `RST`  in  1: synchronous, active-high reset.
- `SC_VALID`  in  1: one-cycle strobe; `SC_DATA` is valid this cycle; synchronous to `CLK`.
- `SC_DATA`  in  8: scancode byte.
- `IOBUS_ADDR`  in  32: CPU IOBUS address.
- `IOBUS_OUT`  in  32: CPU write data.
- `IOBUS_WR`  in  1: CPU write strobe.
- `IOBUS_IN`  out  32: read data, combinational from `IOBUS_ADDR`; 0 on a non-matching address.
- `INTR`  out  1: registered one-cycle interrupt pulse.

## Operation
- Storage: `DEPTH` x 8 register array. Read pointer and write pointer are log2(DEPTH) bits and wrap modulo `DEPTH`. `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push: occurs when `SC_VALID`=1 and (count < DEPTH, or a pop occurs in the same cycle). On push, write `SC_DATA` at the write pointer, then increment the write pointer.
- Overflow: if `SC_VALID`=1, count = DEPTH and no pop occurs, the byte is dropped and sticky `ovf` is set. FIFO contents are unchanged.
- Control write: `IOBUS_WR`=1 with `IOBUS_ADDR`=`CTRL_AD` decodes `IOBUS_OUT`:
  - bit0 POP: advance the read pointer if count > 0; ignored when empty.
  - bit1 FLUSH: read pointer, write pointer and count go to 0.
  - bit2 OVF_CLR: clear `ovf`.
  - bit3 IE: load the interrupt enable (`ie`) from this bit on every `CTRL_AD` write.
- Precedence in one cycle:
  - FLUSH beats push and pop. A byte arriving during FLUSH is discarded and does not set `ovf`.
  - Simultaneous push and pop: both happen and count is unchanged, including when full.
  - A new overflow in the same cycle as OVF_CLR leaves `ovf`=1.
- Writes to `DATA_AD`, `STAT_AD` or any other address are ignored.
- Read map (`IOBUS_IN`):
  - `DATA_AD`: {24'b0, head byte}; 32'b0 when empty. Reading does not pop.
  - `STAT_AD`: bits[12:8]=count (zero-extended, truncated to 5 bits for `DEPTH`=16), bit2=`ovf`, bit1=full (count==DEPTH), bit0=not_empty; all other bits 0.
  - `CTRL_AD`: {28'b0, `ie`, 3'b0}.
- Interrupt: `INTR` is 1 in the cycle after a successful push while `ie`=1, otherwise 0. Dropped or flushed bytes produce no pulse.
- Reset values: all pointers 0, count 0, `ovf` 0, `ie` 0, `INTR` 0. Array contents are don't-care, but `DATA_AD` reads 0 because the FIFO is empty. Reset mid-operation discards all buffered bytes and wins over any push or control write in the same cycle.

## Timing
- Byte presented on `SC_VALID` in cycle N:
  - visible at `DATA_AD` and in `STAT_AD` count from cycle N+1;
  - `INTR` high in cycle N+1 only.
- POP written in cycle N: the new head is visible from cycle N+1.
- `IOBUS_IN` is purely combinational from the address and current registered state, with no added read latency. This matches the CPU's same-cycle load sampling.
- Sustained throughput: one push and one pop per cycle. No stall or backpressure is given to the driver; bytes beyond capacity are dropped with `ovf` set.

## Test plan
- Reset, then read all three addresses: `DATA_AD`=0, `STAT_AD`=0, `CTRL_AD`=0, `INTR`=0.
- Set `ie` (write 0x8 to `CTRL_AD`), push 0x1C, then read `DATA_AD` (0x1C) and `STAT_AD` (0x101). Check `INTR` pulses exactly one cycle, one cycle after the strobe. Write 0x1 to `CTRL_AD`, then `STAT_AD`=0.
- Push 0xE0, 0xF0, 0x6B in back-to-back cycles. Pop three times, reading `DATA_AD` before each pop: 0xE0, 0xF0, 0x6B. After the third pop, `DATA_AD`=0.
- Push 17 bytes 0x00..0x10 with `DEPTH`=16, then read `STAT_AD`=0x1007 (count 16, ovf, full, not_empty). Drain the FIFO: 0x00..0x0F in order and 0x10 absent. Write 0x4 to `CTRL_AD`, then bit2 reads 0.
- With the FIFO full, apply push 0xAA and POP in the same cycle: `ovf` stays 0 and count stays 16. Drain and check 0xAA is last. Then run 40 push/pop cycles so the pointers wrap, checking order throughout.
- Push two bytes, then apply FLUSH in the same cycle as a push of 0x55: count=0, `INTR` stays 0, `ovf` stays 0. Assert `RST` in the same cycle as a push: all outputs return to reset values.
